// File: rtl/scanline_prefetch_buffer_pkg.sv
// Shared types and defaults for the scanline prefetch buffer.
package scanline_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam int DEF_PIX_W    = 4;
  localparam int DEF_WORD_W   = 16;
  localparam int DEF_LINE_PIX = 640;
  localparam int DEF_LINES    = 480;

  // SRAM words needed to hold one visible line.
  function automatic int words_per_line(input int line_pix, input int pix_w, input int word_w);
    return line_pix / (word_w / pix_w);
  endfunction

endpackage

// File: rtl/scanline_prefetch_buffer_if.sv
// Read-request bus between the prefetch buffer and the SRAM arbiter.
interface scanline_prefetch_buffer_if #(
  parameter int ADDR_W = 20,
  parameter int WORD_W = 16
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/scanline_prefetch_buffer_line_bank_ram.sv
// Two line banks in one simple dual-port RAM; registered read port.
module line_bank_ram #(
  parameter int WORD_W = 16,
  parameter int WPL    = 160,
  parameter int WIDX_W = 8
) (
  input  logic              Clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [WIDX_W-1:0] wword,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rbank,
  input  logic [WIDX_W-1:0] rword,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2][WPL];

  // Write one fetched word and read one display word every cycle.
  // NOTE: the array has no reset so it maps onto block RAM; stale contents
  // are harmless because a bank is only displayed after it was written.
  // NOTE: non-blocking assignments keep read-during-write ordering
  // independent of process scheduling.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[wbank][wword] <= wdata;
    end
    rdata <= mem[rbank][rword];
  end

endmodule

// File: rtl/scanline_prefetch_buffer.sv
// Ping-pong scanline buffer: displays one bank while fetching the next line
// from the SRAM frame buffer into the other.
module scanline_prefetch_buffer
  import scanline_pkg::*;
#(
  parameter int PIX_W    = DEF_PIX_W,
  parameter int WORD_W   = DEF_WORD_W,
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int LINES    = DEF_LINES,
  parameter int ADDR_W   = 20
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        line_start,
  input  logic [9:0]                  next_line,
  input  logic                        frame_start,
  input  logic                        page_sel,
  scanline_prefetch_buffer_if.master  mem,
  input  logic [9:0]                  rd_x,
  output logic [PIX_W-1:0]            rd_pix,
  output logic                        fetch_busy,
  output logic                        underrun
);

  localparam int PPW    = WORD_W / PIX_W;
  localparam int WPL    = words_per_line(LINE_PIX, PIX_W, WORD_W);
  localparam int WIDX_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int OFF_W  = (PPW > 1) ? $clog2(PPW) : 1;

  fetch_state_e      state_q, state_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [9:0]        line_q, line_d;
  logic              fetch_page_q, fetch_page_d;
  logic              page_q, page_d;
  logic              disp_bank_q, disp_bank_d;
  logic              underrun_q, underrun_d;
  logic              pix_ok_q;
  logic [OFF_W-1:0]  off_q;

  logic              ack_fire;
  logic              last_word;
  logic              rd_in_line;
  logic [WIDX_W-1:0] rd_word;
  logic [WORD_W-1:0] ram_rdata;

  assign ack_fire   = (state_q == FETCH) && mem.mem_ack;
  assign last_word  = (word_idx_q == WIDX_W'(WPL - 1));
  assign rd_in_line = (32'(rd_x) < 32'(LINE_PIX));
  assign rd_word    = rd_in_line ? WIDX_W'(32'(rd_x) / 32'(PPW)) : '0;

  // Next-state logic: word advance on ack, page latch, bank swap on line_start.
  // NOTE: every target gets its hold value first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    line_d       = line_q;
    fetch_page_d = fetch_page_q;
    page_d       = page_q;
    disp_bank_d  = disp_bank_q;
    underrun_d   = underrun_q;

    if (ack_fire) begin
      if (last_word) begin
        state_d    = IDLE;
        word_idx_d = '0;
      end else begin
        word_idx_d = word_idx_q + WIDX_W'(1);
      end
    end

    if (frame_start) begin
      page_d = page_sel;
    end

    // A line completing in this very cycle is not an underrun.
    if (line_start) begin
      if ((state_q == FETCH) && !(ack_fire && last_word)) begin
        underrun_d = 1'b1;
      end
      disp_bank_d  = ~disp_bank_q;
      line_d       = next_line;
      fetch_page_d = frame_start ? page_sel : page_q;
      word_idx_d   = '0;
      state_d      = (32'(next_line) < 32'(LINES)) ? FETCH : IDLE;
    end
  end

  // State register plus the read-side column offset/valid pipeline.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      word_idx_q   <= '0;
      line_q       <= '0;
      fetch_page_q <= 1'b0;
      page_q       <= 1'b0;
      disp_bank_q  <= 1'b0;
      underrun_q   <= 1'b0;
      pix_ok_q     <= 1'b0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      line_q       <= line_d;
      fetch_page_q <= fetch_page_d;
      page_q       <= page_d;
      disp_bank_q  <= disp_bank_d;
      underrun_q   <= underrun_d;
      pix_ok_q     <= rd_in_line;
      off_q        <= OFF_W'(32'(rd_x) % 32'(PPW));
    end
  end

  // Fetches always land in the bank that is not on display.
  line_bank_ram #(
    .WORD_W (WORD_W),
    .WPL    (WPL),
    .WIDX_W (WIDX_W)
  ) u_ram (
    .Clk   (Clk),
    .we    (ack_fire && !Reset),
    .wbank (~disp_bank_q),
    .wword (word_idx_q),
    .wdata (mem.mem_rdata),
    .rbank (disp_bank_q),
    .rword (rd_word),
    .rdata (ram_rdata)
  );

  assign mem.mem_req  = (state_q == FETCH);
  assign mem.mem_addr = ADDR_W'((fetch_page_q ? 32'(LINES * WPL) : 32'd0)
                                + 32'(line_q) * 32'(WPL) + 32'(word_idx_q));
  assign fetch_busy   = (state_q == FETCH);
  assign underrun     = underrun_q;
  assign rd_pix       = pix_ok_q ? ram_rdata[int'(off_q) * PIX_W +: PIX_W] : '0;

endmodule

// File: tb/tb_scanline_prefetch_buffer.sv
// Self-checking bench for scanline_prefetch_buffer with a pixel-level model.
module tb_scanline_prefetch_buffer;

  localparam int PIX_W    = 4;
  localparam int WORD_W   = 16;
  localparam int LINE_PIX = 640;
  localparam int LINES    = 480;
  localparam int ADDR_W   = 20;
  localparam int PPW      = WORD_W / PIX_W;
  localparam int WPL      = LINE_PIX / PPW;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             line_start = 1'b0;
  logic [9:0]       next_line = '0;
  logic             frame_start = 1'b0;
  logic             page_sel = 1'b0;
  logic [9:0]       rd_x = '0;
  logic [PIX_W-1:0] rd_pix;
  logic             fetch_busy;
  logic             underrun;

  scanline_prefetch_buffer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) mem_bus ();

  scanline_prefetch_buffer #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .LINE_PIX(LINE_PIX), .LINES(LINES), .ADDR_W(ADDR_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .line_start  (line_start),
    .next_line   (next_line),
    .frame_start (frame_start),
    .page_sel    (page_sel),
    .mem         (mem_bus),
    .rd_x        (rd_x),
    .rd_pix      (rd_pix),
    .fetch_busy  (fetch_busy),
    .underrun    (underrun)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: displayed bank, pixel contents per bank, fetch progress.
  bit               m_disp, m_page, m_fpage, m_underrun, m_fetching;
  int               m_line, m_word;
  logic [PIX_W-1:0] m_pix   [2][LINE_PIX];
  bit               m_known [2][LINE_PIX];
  int               ack_count;
  int               data_mode;
  logic [15:0]      salt;
  logic [PIX_W-1:0] exp_rd;
  bit               exp_rd_known;

  function automatic logic [15:0] sram_word(input logic [ADDR_W-1:0] a);
    if (data_mode == 0) return 16'h3210 + a[15:0];
    return (a[15:0] * 16'd40503) ^ salt;
  endfunction

  function automatic int exp_addr();
    return (m_fpage ? LINES * WPL : 0) + m_line * WPL + m_word;
  endfunction

  // One clock: drive inputs at negedge, advance model, return at next negedge.
  task automatic step(input bit ls, input int nl, input bit fs, input bit ps,
                      input bit ack_en, input bit rst);
    bit          acked;
    logic [15:0] d;
    int          wb;
    Reset       = rst;
    line_start  = ls;
    next_line   = 10'(nl);
    frame_start = fs;
    page_sel    = ps;
    acked = ack_en && !rst && (mem_bus.mem_req === 1'b1);
    mem_bus.mem_ack   = acked;
    mem_bus.mem_rdata = acked ? sram_word(mem_bus.mem_addr) : 16'($urandom());
    if (int'(rd_x) >= LINE_PIX) begin
      exp_rd = '0;
      exp_rd_known = 1'b1;
    end else begin
      exp_rd = m_pix[m_disp][rd_x];
      exp_rd_known = m_known[m_disp][rd_x];
    end
    if (rst) begin
      exp_rd = '0; exp_rd_known = 1'b1;
      m_disp = 0; m_page = 0; m_fpage = 0; m_underrun = 0; m_fetching = 0;
      m_line = 0; m_word = 0;
    end else begin
      if (acked && m_fetching) begin
        d  = sram_word(ADDR_W'(exp_addr()));
        wb = m_disp ? 0 : 1;
        for (int k = 0; k < PPW; k++) begin
          m_pix[wb][m_word * PPW + k]   = d[k * PIX_W +: PIX_W];
          m_known[wb][m_word * PPW + k] = 1'b1;
        end
        m_word++;
        ack_count++;
        if (m_word == WPL) begin
          m_fetching = 0;
          m_word = 0;
        end
      end
      if (fs) m_page = ps;
      if (ls) begin
        if (m_fetching) m_underrun = 1;
        m_disp = !m_disp;
        m_line = nl;
        m_fpage = m_page;
        m_word = 0;
        m_fetching = (nl < LINES);
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0; line_start = 1'b0; frame_start = 1'b0; mem_bus.mem_ack = 1'b0;
  endtask

  // Drive acks every `period` cycles until the model's fetch completes,
  // checking the request bus each cycle.
  task automatic run_fetch(input int period, input int max_cycles);
    int                cyc;
    bit                ack_now, prev_hold;
    logic [ADDR_W-1:0] prev_addr;
    cyc = 0; prev_hold = 0; prev_addr = '0;
    while (m_fetching && cyc < max_cycles) begin
      ack_now = ((cyc % period) == period - 1);
      n_checks++;
      if (mem_bus.mem_req !== 1'b1) $display("FAIL fetch_req: got %b expected 1", mem_bus.mem_req);
      else n_pass++;
      n_checks++;
      if (fetch_busy !== 1'b1) $display("FAIL fetch_busy: got %b expected 1", fetch_busy);
      else n_pass++;
      n_checks++;
      if (mem_bus.mem_addr !== ADDR_W'(exp_addr()))
        $display("FAIL fetch_addr: got %0d expected %0d", mem_bus.mem_addr, exp_addr());
      else n_pass++;
      if (prev_hold) begin
        n_checks++;
        if (mem_bus.mem_addr !== prev_addr)
          $display("FAIL addr_hold: got %0d expected %0d", mem_bus.mem_addr, prev_addr);
        else n_pass++;
      end
      prev_addr = mem_bus.mem_addr;
      prev_hold = !ack_now;
      step(0, 0, 0, 0, ack_now, 0);
      cyc++;
    end
    n_checks++;
    if (m_fetching) $display("FAIL fetch_timeout: got %0d cycles expected completion", cyc);
    else if (mem_bus.mem_req !== 1'b0) $display("FAIL req_after_fetch: got %b expected 0", mem_bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", mem_bus.mem_req);
    else n_pass++;
    n_checks++;
    if (mem_bus.mem_addr !== '0) $display("FAIL reset_addr: got %0d expected 0", mem_bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (fetch_busy !== 1'b0 || underrun !== 1'b0)
      $display("FAIL reset_flags: got busy=%b underrun=%b expected 0 0", fetch_busy, underrun);
    else n_pass++;
    n_checks++;
    if (rd_pix !== '0) $display("FAIL reset_pix: got %h expected 0", rd_pix);
    else n_pass++;
  endtask

  task automatic test_full_fetch();
    int start_acks;
    data_mode = 0;
    start_acks = ack_count;
    step(1, 0, 0, 0, 0, 0);
    run_fetch(1, 400);
    n_checks++;
    if (ack_count - start_acks != WPL) $display("FAIL full_ack_count: got %0d expected %0d", ack_count - start_acks, WPL);
    else n_pass++;
    step(1, 1, 0, 0, 0, 0);
    for (int x = 0; x < 4; x++) begin
      rd_x = 10'(x);
      step(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (rd_pix !== PIX_W'(x)) $display("FAIL read_pix%0d: got %h expected %h", x, rd_pix, x);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      rd_x = 10'($urandom_range(0, LINE_PIX - 1));
      step(0, 0, 0, 0, 1, 0);
      if (exp_rd_known) begin
        n_checks++;
        if (rd_pix !== exp_rd) $display("FAIL read_rand x=%0d: got %h expected %h", rd_x, rd_pix, exp_rd);
        else n_pass++;
      end
    end
    run_fetch(1, 400);
  endtask

  task automatic test_slow_ack();
    int start_acks;
    data_mode = 1;
    salt = 16'($urandom());
    start_acks = ack_count;
    step(1, $urandom_range(0, LINES - 1), 0, 0, 0, 0);
    run_fetch(3, 1000);
    n_checks++;
    if (ack_count - start_acks != WPL) $display("FAIL slow_ack_count: got %0d expected %0d", ack_count - start_acks, WPL);
    else n_pass++;
    n_checks++;
    if (underrun !== 1'b0 || fetch_busy !== 1'b0)
      $display("FAIL slow_flags: got underrun=%b busy=%b expected 0 0", underrun, fetch_busy);
    else n_pass++;
  endtask

  task automatic test_page_flip();
    step(0, 0, 1, 1, 0, 0);
    step(1, 2, 0, 0, 0, 0);
    n_checks++;
    if (mem_bus.mem_addr !== ADDR_W'(77120)) $display("FAIL page1_addr: got %0d expected 77120", mem_bus.mem_addr);
    else n_pass++;
    for (int i = 0; i < 50; i++) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    run_fetch(1, 400);
    step(1, 3, 1, 0, 0, 0);
    n_checks++;
    if (mem_bus.mem_addr !== ADDR_W'(480)) $display("FAIL page0_addr: got %0d expected 480", mem_bus.mem_addr);
    else n_pass++;
    run_fetch(2, 800);
  endtask

  task automatic test_out_of_range();
    step(1, 500, 0, 0, 0, 0);
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || fetch_busy !== 1'b0)
      $display("FAIL oor_req: got req=%b busy=%b expected 0 0", mem_bus.mem_req, fetch_busy);
    else n_pass++;
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL oor_underrun: got %b expected 0", underrun);
    else n_pass++;
    rd_x = 10'd700;
    step(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (rd_pix !== '0) $display("FAIL oor_pix: got %h expected 0", rd_pix);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd_x = 10'($urandom_range(0, LINE_PIX - 1));
      step(0, 0, 0, 0, 0, 0);
      if (exp_rd_known) begin
        n_checks++;
        if (rd_pix !== exp_rd) $display("FAIL swap_pix x=%0d: got %h expected %h", rd_x, rd_pix, exp_rd);
        else n_pass++;
      end
    end
  endtask

  task automatic test_underrun();
    int r2;
    step(0, 0, 0, 0, 0, 1);
    step(1, $urandom_range(0, LINES - 1), 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 1, 0);
    r2 = $urandom_range(0, LINES - 1);
    step(1, r2, 0, 0, 0, 0);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL underrun_set: got %b expected 1", underrun);
    else n_pass++;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== ADDR_W'(r2 * WPL))
      $display("FAIL underrun_restart: got req=%b addr=%0d expected 1 %0d", mem_bus.mem_req, mem_bus.mem_addr, r2 * WPL);
    else n_pass++;
    run_fetch(1, 400);
    n_checks++;
    if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", underrun);
    else n_pass++;
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL underrun_clear: got %b expected 0", underrun);
    else n_pass++;
  endtask

  task automatic test_final_ack_collision();
    int r2, guard;
    step(0, 0, 0, 0, 0, 1);
    step(1, $urandom_range(0, LINES - 1), 0, 0, 0, 0);
    guard = 0;
    while (m_fetching && m_word < WPL - 1 && guard < 400) begin
      step(0, 0, 0, 0, 1, 0);
      guard++;
    end
    r2 = $urandom_range(0, LINES - 1);
    step(1, r2, 0, 0, 1, 0);
    n_checks++;
    if (underrun !== 1'b0) $display("FAIL collide_underrun: got %b expected 0", underrun);
    else n_pass++;
    n_checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== ADDR_W'(r2 * WPL))
      $display("FAIL collide_restart: got req=%b addr=%0d expected 1 %0d", mem_bus.mem_req, mem_bus.mem_addr, r2 * WPL);
    else n_pass++;
    for (int x = LINE_PIX - 4; x < LINE_PIX; x++) begin
      rd_x = 10'(x);
      step(0, 0, 0, 0, 1, 0);
      n_checks++;
      if (!exp_rd_known || rd_pix !== exp_rd)
        $display("FAIL collide_last_word x=%0d: got %h expected %h", x, rd_pix, exp_rd);
      else n_pass++;
    end
    run_fetch(1, 400);
  endtask

  task automatic test_reset_mid_fetch();
    step(1, $urandom_range(0, LINES - 1), 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0);
    rd_x = 10'd5;
    step(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || fetch_busy !== 1'b0)
      $display("FAIL midreset_req: got req=%b busy=%b expected 0 0", mem_bus.mem_req, fetch_busy);
    else n_pass++;
    n_checks++;
    if (rd_pix !== '0) $display("FAIL midreset_pix: got %h expected 0", rd_pix);
    else n_pass++;
    step(0, 0, 0, 0, 1, 0);
    n_checks++;
    if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== '0)
      $display("FAIL midreset_idle: got req=%b addr=%0d expected 0 0", mem_bus.mem_req, mem_bus.mem_addr);
    else n_pass++;
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < LINE_PIX; p++) m_known[b][p] = 1'b0;
    ack_count = 0;
    data_mode = 0;
    salt = '0;
    @(negedge Clk);
    test_reset();
    test_full_fetch();
    test_slow_ack();
    test_page_flip();
    test_out_of_range();
    test_underrun();
    test_final_ack_collision();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
